// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide engine, one bit per cycle.
// Operands become magnitudes at acceptance, a radix-2 unsigned loop runs for
// XLEN cycles, and the sign fix-up is applied while the result is registered.
// The hart/rd tags ride along so the core can route the writeback.
// Optional macro MULDIV_FASTPATH_EN: divide-by-zero, signed overflow and
// multiply-by-zero bypass RUN and complete one cycle after acceptance.
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int HART_ID_W  = 1,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  muldiv_start,
  input  logic [2:0]            muldiv_op,
  input  logic [XLEN-1:0]       muldiv_a,
  input  logic [XLEN-1:0]       muldiv_b,
  input  logic [HART_ID_W-1:0]  muldiv_hart_id,
  input  logic [REG_ADDR_W-1:0] muldiv_rd,
  output logic                  muldiv_busy,
  output logic                  muldiv_done,
  output logic [XLEN-1:0]       muldiv_result,
  output logic [HART_ID_W-1:0]  muldiv_done_hart_id,
  output logic [REG_ADDR_W-1:0] muldiv_done_rd
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int          CNT_W   = $clog2(XLEN);
  localparam logic [2:0]  OP_MUL  = 3'b000;
  localparam logic [XLEN-1:0] ONES    = '1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t                state, state_next;
  logic [2:0]            op_q;
  logic [XLEN-1:0]       a_q;        // raw dividend, returned by REM on b=0
  logic [XLEN-1:0]       b_mag;      // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]     acc;        // mul: {partial, multiplier}; div: {rem, quo}
  logic [CNT_W-1:0]      count;
  logic                  neg_q, neg_r, div_zero_q;
  logic [HART_ID_W-1:0]  hart_q;
  logic [REG_ADDR_W-1:0] rd_q;

  // Operand conditioning at the request port.
  logic            a_signed, b_signed, a_neg, b_neg, accept, is_last, div_zero_in;
  logic [XLEN-1:0] a_mag_in, b_mag_in;

  assign a_signed    = (muldiv_op == 3'b001) || (muldiv_op == 3'b010) ||
                       (muldiv_op == 3'b100) || (muldiv_op == 3'b110);
  assign b_signed    = (muldiv_op == 3'b001) || (muldiv_op == 3'b100) ||
                       (muldiv_op == 3'b110);
  assign a_neg       = a_signed && muldiv_a[XLEN-1];
  assign b_neg       = b_signed && muldiv_b[XLEN-1];
  assign a_mag_in    = a_neg ? (~muldiv_a + 1'b1) : muldiv_a;
  assign b_mag_in    = b_neg ? (~muldiv_b + 1'b1) : muldiv_b;
  assign accept      = (state == S_IDLE) && muldiv_start;
  assign is_last     = (count == CNT_W'(XLEN-1));
  assign div_zero_in = muldiv_op[2] && (muldiv_b == '0);

  // Early-out detection; results match what the full loop would produce.
  logic            fast_hit;
  logic [XLEN-1:0] fast_result;
`ifdef MULDIV_FASTPATH_EN
  logic ovf_in, mul_zero_in;
  assign ovf_in      = muldiv_op[2] && !muldiv_op[0] &&
                       (muldiv_a == INT_MIN) && (muldiv_b == ONES);
  assign mul_zero_in = !muldiv_op[2] && ((muldiv_a == '0) || (muldiv_b == '0));
  assign fast_hit    = div_zero_in || ovf_in || mul_zero_in;
  assign fast_result = mul_zero_in ? '0 :
                       div_zero_in ? (muldiv_op[1] ? muldiv_a : ONES) :
                                     (muldiv_op[1] ? '0 : INT_MIN);
`else
  assign fast_hit    = 1'b0;
  assign fast_result = '0;
`endif

  // One radix-2 step: shift-add for multiply, restoring subtract for divide.
  logic [XLEN:0]     mul_sum, rem_ext, rem_new;
  logic              rem_ge;
  logic [2*XLEN-1:0] acc_next, prod;
  logic [XLEN-1:0]   quo, rem, final_result;

  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
  assign rem_ext  = acc[2*XLEN-1:XLEN-1];
  assign rem_ge   = rem_ext >= {1'b0, b_mag};
  assign rem_new  = rem_ge ? (rem_ext - {1'b0, b_mag}) : rem_ext;
  assign acc_next = op_q[2] ? {rem_new[XLEN-1:0], acc[XLEN-2:0], rem_ge}
                            : {mul_sum, acc[XLEN-1:1]};

  // Sign fix-up applied to the value produced by the final iteration.
  assign prod = neg_q ? (~acc_next + 1'b1) : acc_next;
  assign quo  = acc_next[XLEN-1:0];
  assign rem  = acc_next[2*XLEN-1:XLEN];
  assign final_result = !op_q[2]     ? ((op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]) :
                        div_zero_q   ? (op_q[1] ? a_q : ONES) :
                        op_q[1]      ? (neg_r ? (~rem + 1'b1) : rem) :
                                       (neg_q ? (~quo + 1'b1) : quo);

  // State register.
  // NOTE: every clocked block uses non-blocking (<=) so all flops update from
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state decode.
  // NOTE: the default assignment first keeps every path assigned, so no latch
  // is inferred when a case arm leaves state_next untouched.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (muldiv_start) state_next = fast_hit ? S_DONE : S_RUN;
      S_RUN:  if (is_last)      state_next = S_DONE;
      S_DONE:                   state_next = S_IDLE;
      default:                  state_next = S_IDLE;
    endcase
  end

  // Datapath: latch the request on acceptance, iterate while running.
  // NOTE: the datapath is reset too; it is small and a clean reset keeps
  // X out of the result mux in simulation after an aborted operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      a_q        <= '0;
      b_mag      <= '0;
      acc        <= '0;
      count      <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div_zero_q <= 1'b0;
      hart_q     <= '0;
      rd_q       <= '0;
    end else if (accept) begin
      op_q       <= muldiv_op;
      a_q        <= muldiv_a;
      b_mag      <= b_mag_in;
      acc        <= {{XLEN{1'b0}}, a_mag_in};
      count      <= '0;
      neg_q      <= a_neg ^ b_neg;
      neg_r      <= a_neg;
      div_zero_q <= div_zero_in;
      hart_q     <= muldiv_hart_id;
      rd_q       <= muldiv_rd;
    end else if (state == S_RUN) begin
      acc        <= acc_next;
      count      <= count + CNT_W'(1);
    end
  end

  // Registered outputs; result and tags load only on entry to DONE and hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      muldiv_busy         <= 1'b0;
      muldiv_done         <= 1'b0;
      muldiv_result       <= '0;
      muldiv_done_hart_id <= '0;
      muldiv_done_rd      <= '0;
    end else begin
      muldiv_busy <= (state_next != S_IDLE);
      muldiv_done <= (state_next == S_DONE);
      if (accept && fast_hit) begin
        muldiv_result       <= fast_result;
        muldiv_done_hart_id <= muldiv_hart_id;
        muldiv_done_rd      <= muldiv_rd;
      end else if ((state == S_RUN) && is_last) begin
        muldiv_result       <= final_result;
        muldiv_done_hart_id <= hart_q;
        muldiv_done_rd      <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed table of RV32M vectors plus hand-written sequences
// for ignored start and mid-operation reset. Honours MULDIV_FASTPATH_EN when
// computing the expected completion cycle.
module tb_muldiv_unit;
  localparam int XLEN    = 32;
  localparam int SLOW_LAT = XLEN + 1;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            muldiv_start;
  logic [2:0]      muldiv_op;
  logic [XLEN-1:0] muldiv_a, muldiv_b;
  logic            muldiv_hart_id;
  logic [4:0]      muldiv_rd;
  logic            muldiv_busy, muldiv_done;
  logic [XLEN-1:0] muldiv_result;
  logic            muldiv_done_hart_id;
  logic [4:0]      muldiv_done_rd;

  muldiv_unit #(.XLEN(XLEN), .HART_ID_W(1), .REG_ADDR_W(5)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .muldiv_start        (muldiv_start),
    .muldiv_op           (muldiv_op),
    .muldiv_a            (muldiv_a),
    .muldiv_b            (muldiv_b),
    .muldiv_hart_id      (muldiv_hart_id),
    .muldiv_rd           (muldiv_rd),
    .muldiv_busy         (muldiv_busy),
    .muldiv_done         (muldiv_done),
    .muldiv_result       (muldiv_result),
    .muldiv_done_hart_id (muldiv_done_hart_id),
    .muldiv_done_rd      (muldiv_done_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        hart;
    logic [4:0]  rd;
    bit          fast;
  } vec_t;

  vec_t vecs [18];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for done; returns at the negedge of
  // the done cycle with the cycle number counted from acceptance.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic hart, input logic [4:0] rd,
                        output logic [31:0] res, output logic hart_o, output logic [4:0] rd_o,
                        output int lat, output bit busy_ok);
    @(negedge clk);
    muldiv_start = 1'b1; muldiv_op = op; muldiv_a = a; muldiv_b = b;
    muldiv_hart_id = hart; muldiv_rd = rd;
    @(negedge clk);
    muldiv_start = 1'b0;
    res = '0; hart_o = 1'b0; rd_o = '0; lat = 0; busy_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      if (muldiv_busy !== 1'b1) busy_ok = 1'b0;
      if (muldiv_done === 1'b1) begin
        lat = c; res = muldiv_result; hart_o = muldiv_done_hart_id; rd_o = muldiv_done_rd;
        break;
      end
      @(negedge clk);
    end
  endtask

  function automatic int exp_lat(input bit fast);
`ifdef MULDIV_FASTPATH_EN
    return fast ? 1 : SLOW_LAT;
`else
    return fast ? SLOW_LAT : SLOW_LAT;
`endif
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    logic        hart_o;
    logic [4:0]  rd_o;
    int          lat;
    bit          busy_ok;
    int          n_done;
    int          done_cyc;
    logic [31:0] done_res;
    logic        done_hart;
    logic [4:0]  done_rd;

    vecs[0]  = '{MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1, 5'd5,  1'b0};
    vecs[1]  = '{MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 5'd1,  1'b0};
    vecs[2]  = '{MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd2,  1'b0};
    vecs[3]  = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 5'd3,  1'b0};
    vecs[4]  = '{DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b1, 5'd4,  1'b0};
    vecs[5]  = '{REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 5'd6,  1'b0};
    vecs[6]  = '{DIVU,   32'd100,      32'd7,        32'd14,       1'b1, 5'd7,  1'b0};
    vecs[7]  = '{REMU,   32'd100,      32'd7,        32'd2,        1'b0, 5'd8,  1'b0};
    vecs[8]  = '{DIVU,   32'h1234,     32'd0,        32'hFFFFFFFF, 1'b1, 5'd9,  1'b1};
    vecs[9]  = '{REMU,   32'h1234,     32'd0,        32'h1234,     1'b0, 5'd10, 1'b1};
    vecs[10] = '{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 5'd11, 1'b1};
    vecs[11] = '{REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 5'd12, 1'b1};
    vecs[12] = '{DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1'b1, 5'd13, 1'b1};
    vecs[13] = '{REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b0, 5'd14, 1'b1};
    vecs[14] = '{MUL,    32'd0,        32'd5,        32'd0,        1'b1, 5'd15, 1'b1};
    vecs[15] = '{MULHU,  32'h00010000, 32'h00010000, 32'd1,        1'b0, 5'd16, 1'b0};
    vecs[16] = '{DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b1, 5'd17, 1'b0};
    vecs[17] = '{REM,    32'd7,        32'hFFFFFFFE, 32'd1,        1'b0, 5'd31, 1'b0};

    // Reset state.
    rst_n = 1'b0; muldiv_start = 1'b0; muldiv_op = '0; muldiv_a = '0; muldiv_b = '0;
    muldiv_hart_id = 1'b0; muldiv_rd = '0;
    repeat (2) @(negedge clk);
    check("reset busy",   {31'd0, muldiv_busy}, 32'd0);
    check("reset done",   {31'd0, muldiv_done}, 32'd0);
    check("reset result", muldiv_result, 32'd0);
    check("reset tags",   {26'd0, muldiv_done_hart_id, muldiv_done_rd}, 32'd0);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hart, vecs[i].rd,
             res, hart_o, rd_o, lat, busy_ok);
      check($sformatf("vec%0d result", i),  res, vecs[i].exp);
      check($sformatf("vec%0d hart", i),    {31'd0, hart_o}, {31'd0, vecs[i].hart});
      check($sformatf("vec%0d rd", i),      {27'd0, rd_o}, {27'd0, vecs[i].rd});
      check($sformatf("vec%0d latency", i), lat, exp_lat(vecs[i].fast));
      check($sformatf("vec%0d busy held", i), {31'd0, busy_ok}, 32'd1);
      @(negedge clk);
      check($sformatf("vec%0d done pulse", i), {30'd0, muldiv_done, muldiv_busy}, 32'd0);
      check($sformatf("vec%0d result held", i), muldiv_result, vecs[i].exp);
    end

    // Start while busy must be ignored.
    @(negedge clk);
    muldiv_start = 1'b1; muldiv_op = DIVU; muldiv_a = 32'd100; muldiv_b = 32'd7;
    muldiv_hart_id = 1'b0; muldiv_rd = 5'd3;
    @(negedge clk);
    muldiv_start = 1'b0;
    n_done = 0; done_cyc = 0; done_res = '0; done_hart = 1'b0; done_rd = '0;
    for (int c = 1; c <= 45; c++) begin
      if (muldiv_done === 1'b1) begin
        n_done++;
        if (n_done == 1) begin
          done_cyc = c; done_res = muldiv_result; done_hart = muldiv_done_hart_id; done_rd = muldiv_done_rd;
        end
      end
      if (c == 10) begin
        muldiv_start = 1'b1; muldiv_op = MUL; muldiv_a = 32'd1; muldiv_b = 32'd1;
        muldiv_hart_id = 1'b1; muldiv_rd = 5'd9;
      end else begin
        muldiv_start = 1'b0;
      end
      @(negedge clk);
    end
    check("ignored start done count", n_done, 1);
    check("ignored start latency",    done_cyc, SLOW_LAT);
    check("ignored start result",     done_res, 32'd14);
    check("ignored start tags",       {26'd0, done_hart, done_rd}, {26'd0, 1'b0, 5'd3});

    // Reset in cycle 15 of a MUL aborts it.
    muldiv_start = 1'b1; muldiv_op = MUL; muldiv_a = 32'd7; muldiv_b = 32'd3;
    muldiv_hart_id = 1'b1; muldiv_rd = 5'd5;
    @(negedge clk);
    muldiv_start = 1'b0;
    repeat (14) @(negedge clk);
    check("pre-abort busy", {31'd0, muldiv_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy",   {31'd0, muldiv_busy}, 32'd0);
    check("abort done",   {31'd0, muldiv_done}, 32'd0);
    check("abort result", muldiv_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0; busy_ok = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (muldiv_done === 1'b1) n_done++;
      if (muldiv_busy !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
    end
    check("post-abort no done", n_done, 0);
    check("post-abort idle",    {31'd0, busy_ok}, 32'd1);
    run_op(MUL, 32'd6, 32'd7, 1'b0, 5'd20, res, hart_o, rd_o, lat, busy_ok);
    check("recovery result",  res, 32'd42);
    check("recovery latency", lat, SLOW_LAT);
    check("recovery tags",    {26'd0, hart_o, rd_o}, {26'd0, 1'b0, 5'd20});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide engine that sits directly downstream of cpu_top.
- Consumes cpu_top's muldiv_start/op/a/b/hart_id/rd request bundle.
- Returns muldiv_busy/done/result/done_hart_id/done_rd.
- One operation in flight, radix-2, one bit per cycle. The hart and rd tag are carried through so the core can route the writeback.

Parameters:
- XLEN, 32, operand/result width (matches `XLEN).
- HART_ID_W, 1, hart tag width (matches `HART_ID_W).
- REG_ADDR_W, 5, destination register tag width (matches `REG_ADDR_W).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  reset; one clock, reset asynchronous, active-low.
- muldiv_start  input  1  request strobe; accepted only when busy=0.
- muldiv_op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- muldiv_a  input  XLEN  rs1 operand.
- muldiv_b  input  XLEN  rs2 operand.
- muldiv_hart_id  input  HART_ID_W  issuing hart tag.
- muldiv_rd  input  REG_ADDR_W  destination register tag.
- muldiv_busy  output  1  high while an operation is held (RUN or DONE).
- muldiv_done  output  1  one-cycle completion pulse.
- muldiv_result  output  XLEN  result, valid when done=1.
- muldiv_done_hart_id  output  HART_ID_W  tag of the completing op.
- muldiv_done_rd  output  REG_ADDR_W  rd of the completing op.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE; busy, done, result, done_hart_id, done_rd all 0.
  - Any in-flight op is discarded and no done is produced for it.
- FSM states IDLE, RUN, DONE:
  - IDLE: start=1 at a rising edge latches op, a, b, hart_id and rd, then goes to RUN with count=0.
  - RUN: one iteration per cycle; after XLEN iterations, go to DONE.
  - DONE: done=1 for exactly one cycle with result and tags; then return to IDLE.
- Latency: start sampled at edge 0 → RUN occupies cycles 1..XLEN → done high in cycle XLEN+1 (33 at default). Next start is accepted no earlier than the edge ending the DONE cycle.
- busy is registered. It is 1 from the cycle after acceptance through the DONE cycle, and 0 in IDLE.
- start while busy=1 is ignored: no latch, no state change, no error. The core must hold off.
- Outputs are registered and hold their last values after done falls. Only done=1 qualifies them.
- Signed handling: operands are converted to magnitudes per op signedness, and the iteration runs unsigned.
  - MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - DIV/REM: both signed.
  - Final negate applied for MULH/MULHSU when the operand signs differ.
  - Quotient negated when the operand signs differ; remainder takes the dividend's sign.
- Multiply: shift-add into a 2*XLEN accumulator. MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide: restoring, one quotient bit per cycle.
- Divide by zero (b=0):
  - DIV/DIVU quotient = all-ones (0xFFFFFFFF).
  - REM/REMU = a unchanged.
  - Full latency unless the optional feature is enabled.
- Signed overflow, DIV with a=0x80000000, b=0xFFFFFFFF: quotient 0x80000000, REM 0. No exception is raised.
- No trap or exception output exists; all results are architectural RV32M values.

Optional Feature:
- Macro MULDIV_FASTPATH_EN.
- Defined:
  - Divide-by-zero, signed overflow, and multiply with either operand 0 skip RUN and go IDLE→DONE.
  - done is high in cycle 1 after acceptance; busy is high in that cycle only.
  - Result values are identical to the slow path.
- Undefined: every op takes the full XLEN+1 latency. Bit-exact results are unchanged.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (hart 1, rd 5) → done in cycle 33, result 0xFFFFFFEB, done_hart_id=1, done_rd=5; busy high cycles 1..33.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF. MULHU same operands → 0xFFFFFFFE.
- DIV -7/2 → 0xFFFFFFFD. REM -7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 0x1234/0 → 0xFFFFFFFF. REMU 0x1234/0 → 0x1234. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM same operands → 0.
  - Done arrives in cycle 33, or in cycle 1 with MULDIV_FASTPATH_EN.
- Second start pulsed in cycle 10 of a running DIV with different tags → ignored. Exactly one done, carrying the first op's result and tags.
- rst_n dropped in cycle 15 of a MUL → busy and done go to 0 immediately. No done after rst_n rises. A new op then completes normally.
